// File: rtl/mem_bridge.sv
// Bridges a single-cycle processor access strobe onto a four-phase request/acknowledge
// external memory handshake, with two memory-mapped I/O registers and sticky error flags.
module mem_bridge #(
    parameter int unsigned TIMEOUT     = 64,
    parameter logic [11:0] IO_OUT_ADDR = 12'hFFF,
    parameter logic [11:0] IO_IN_ADDR  = 12'hFFE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_rw,
    input  logic [11:0] cpu_addr,
    input  logic [15:0] cpu_data,
    output logic [15:0] cpu_q,
    output logic        busy,
    output logic        ext_req,
    output logic        ext_we,
    output logic [11:0] ext_addr,
    output logic [15:0] ext_wdata,
    input  logic        ext_ack,
    input  logic [15:0] ext_rdata,
    input  logic [15:0] io_in,
    output logic [15:0] io_out,
    output logic        err_timeout,
    output logic        err_overrun,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state_r;
    logic [7:0] cnt_r;
    logic       timeout_hit_s;
    logic       overrun_hit_s;

    // Error-flag set events; an acknowledge in the last WAIT cycle takes precedence over timeout
    always_comb begin
        timeout_hit_s = 1'b0;
        overrun_hit_s = 1'b0;
        if (state_r == WAIT && !ext_ack && cnt_r == TIMEOUT_LAST) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
        if (cpu_req && state_r != IDLE) begin
            overrun_hit_s = 1'b1;
        end else begin
            overrun_hit_s = 1'b0;
        end
    end

    // Handshake FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            busy        <= 1'b0;
            ext_req     <= 1'b0;
            ext_we      <= 1'b0;
            ext_addr    <= 12'h000;
            ext_wdata   <= 16'h0000;
            cpu_q       <= 16'h0000;
            io_out      <= 16'h0000;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            // Set events win over a simultaneous clear
            err_timeout <= timeout_hit_s | (err_timeout & ~err_clr);
            err_overrun <= overrun_hit_s | (err_overrun & ~err_clr);
            case (state_r)
                IDLE: begin
                    if (cpu_req) begin
                        if (cpu_addr == IO_OUT_ADDR) begin
                            if (cpu_rw) begin
                                io_out <= cpu_data;
                            end else begin
                                cpu_q <= 16'h0000;
                            end
                        end else if (cpu_addr == IO_IN_ADDR) begin
                            if (!cpu_rw) begin
                                cpu_q <= io_in;
                            end
                        end else begin
                            ext_addr  <= cpu_addr;
                            ext_wdata <= cpu_data;
                            ext_we    <= cpu_rw;
                            ext_req   <= 1'b1;
                            busy      <= 1'b1;
                            cnt_r     <= 8'd0;
                            state_r   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r + 8'd1;
                    if (ext_ack) begin
                        if (!ext_we) begin
                            cpu_q <= ext_rdata;
                        end
                        ext_req <= 1'b0;
                        state_r <= RELEASE;
                    end else if (timeout_hit_s) begin
                        if (!ext_we) begin
                            cpu_q <= 16'hFFFF;
                        end
                        ext_req <= 1'b0;
                        state_r <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Wait for the memory to finish its four-phase return to zero
                    if (!ext_ack) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    ext_req <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed scenarios plus randomized accesses,
// checked against a per-transaction outcome model of the bridge.
module tb_mem_bridge;

    localparam int          TIMEOUT = 64;
    localparam logic [11:0] IO_OUT  = 12'hFFF;
    localparam logic [11:0] IO_IN   = 12'hFFE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_rw, ext_ack, err_clr;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_data, ext_rdata, io_in;
    logic [15:0] cpu_q, ext_wdata, io_out;
    logic [11:0] ext_addr;
    logic        busy, ext_req, ext_we, err_timeout, err_overrun;

    int checks = 0;
    int errors = 0;

    // Expected architectural state
    logic [15:0] q_m, io_m;
    logic        eto_m, eov_m;

    mem_bridge #(.TIMEOUT(TIMEOUT), .IO_OUT_ADDR(IO_OUT), .IO_IN_ADDR(IO_IN)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_q(cpu_q), .busy(busy),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata), .io_in(io_in), .io_out(io_out),
        .err_timeout(err_timeout), .err_overrun(err_overrun), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req"}, ext_req, 0);
        chk({tag, "_q"}, cpu_q, q_m);
        chk({tag, "_io"}, io_out, io_m);
        chk({tag, "_eto"}, err_timeout, eto_m);
        chk({tag, "_eov"}, err_overrun, eov_m);
    endtask

    // One external-memory access; the bench plays the memory, acking after dly WAIT cycles
    task automatic mem_access(input logic rw, input logic [11:0] a, input logic [15:0] d,
                              input int dly, input int hold, input logic [15:0] rd,
                              input int ovr_at, input logic clr_with);
        int waits;
        bit acked;
        @(negedge clk);
        cpu_req = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_data = d;
        @(negedge clk);
        cpu_req = 1'b0;
        waits = 0;
        acked = 1'b0;
        while (ext_req === 1'b1 && waits < TIMEOUT + 4) begin
            chk("wait_addr", ext_addr, a);
            chk("wait_we", ext_we, rw);
            chk("wait_wdata", ext_wdata, d);
            chk("wait_busy", busy, 1);
            chk("wait_q", cpu_q, q_m);
            cpu_req = 1'b0;
            err_clr = 1'b0;
            if (waits == ovr_at) begin
                cpu_req = 1'b1; cpu_rw = ~rw; cpu_addr = a ^ 12'h001;
                err_clr = clr_with;
                eov_m = 1'b1;
                if (clr_with) eto_m = 1'b0;
            end
            if (waits == dly) begin
                ext_ack = 1'b1; ext_rdata = rd; acked = 1'b1;
            end
            waits++;
            @(negedge clk);
        end
        cpu_req = 1'b0;
        err_clr = 1'b0;
        chk("wait_count", waits, (dly >= TIMEOUT) ? TIMEOUT : dly + 1);
        if (!rw) q_m = acked ? rd : 16'hFFFF;
        if (!acked) eto_m = 1'b1;
        chk("rel_req", ext_req, 0);
        chk("rel_busy", busy, 1);
        chk("rel_q", cpu_q, q_m);
        for (int h = 1; h < hold && acked; h++) begin
            @(negedge clk);
            chk("rel_hold_busy", busy, 1);
        end
        ext_ack = 1'b0;
        @(negedge clk);
        chk_idle_outputs("done");
    endtask

    // Access to one of the I/O addresses; must complete without leaving IDLE
    task automatic io_op(input logic rw, input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        cpu_req = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_data = d;
        if (a == IO_OUT) begin
            if (rw) io_m = d; else q_m = 16'h0000;
        end else if (a == IO_IN && !rw) begin
            q_m = io_in;
        end
        @(negedge clk);
        cpu_req = 1'b0;
        chk_idle_outputs("io");
    endtask

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = 12'h000; cpu_data = 16'h0000;
        ext_ack = 1'b0; ext_rdata = 16'h0000; io_in = 16'h0000; err_clr = 1'b0;
        q_m = 16'h0000; io_m = 16'h0000; eto_m = 1'b0; eov_m = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_addr", ext_addr, 0);
        chk("reset_wdata", ext_wdata, 0);
        chk("reset_we", ext_we, 0);
        rst_n = 1'b1;

        // Fast read, quick write with delayed ack, timeout, then flag clear
        mem_access(1'b0, 12'h010, 16'h0000, 0, 1, 16'h1234, -1, 1'b0);
        mem_access(1'b1, 12'h020, 16'hBEEF, 5, 1, 16'hAAAA, -1, 1'b0);
        mem_access(1'b0, 12'h030, 16'h0000, TIMEOUT + 10, 1, 16'h0000, -1, 1'b0);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; eto_m = 1'b0;
        chk_idle_outputs("clr");

        // I/O ports, including the ignored and zero-reading directions
        io_in = 16'h5A5A;
        io_op(1'b1, IO_OUT, 16'h00A5);
        io_op(1'b0, IO_IN, 16'h0000);
        io_op(1'b1, IO_IN, 16'h7777);
        io_op(1'b0, IO_OUT, 16'h0000);

        // Overrun, coincident ack/timeout, long ack hold, set-beats-clear
        mem_access(1'b0, 12'h040, 16'h1111, 3, 1, 16'hC0DE, 2, 1'b0);
        mem_access(1'b0, 12'h050, 16'h2222, TIMEOUT - 1, 1, 16'h0BAD, -1, 1'b0);
        mem_access(1'b1, 12'h060, 16'h3333, 1, 3, 16'h0000, -1, 1'b0);
        mem_access(1'b0, 12'h070, 16'h4444, TIMEOUT, 1, 16'h0000, -1, 1'b0);
        mem_access(1'b0, 12'h080, 16'h5555, 4, 2, 16'h6789, 1, 1'b1);

        // Randomized mix of transactions
        for (int i = 0; i < 30; i++) begin
            int k;
            k = $urandom_range(0, 3);
            if (k <= 1) begin
                mem_access(k[0], 12'($urandom_range(0, 12'hFFD)), 16'($urandom),
                           ($urandom_range(0, 3) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 6),
                           $urandom_range(1, 3), 16'($urandom), -1, 1'b0);
            end else if (k == 2) begin
                io_op(1'b1, IO_OUT, 16'($urandom));
            end else begin
                io_in = 16'($urandom);
                io_op(1'($urandom), ($urandom_range(0, 1) == 0) ? IO_IN : IO_OUT, 16'($urandom));
            end
        end

        // Asynchronous reset in the middle of a WAIT, with a stale ack afterwards
        @(negedge clk);
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 12'h123; cpu_data = 16'h9999;
        @(negedge clk);
        cpu_req = 1'b0;
        chk("pre_rst_req", ext_req, 1);
        #2 rst_n = 1'b0;
        #1;
        q_m = 16'h0000; io_m = 16'h0000; eto_m = 1'b0; eov_m = 1'b0;
        chk_idle_outputs("async_rst");
        chk("async_rst_addr", ext_addr, 0);
        chk("async_rst_wdata", ext_wdata, 0);
        chk("async_rst_we", ext_we, 0);
        ext_ack = 1'b1; ext_rdata = 16'hDEAD;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_idle_outputs("stale_ack");
        end
        ext_ack = 1'b0;
        mem_access(1'b0, 12'h200, 16'h0000, 2, 1, 16'h4242, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the number of WAIT cycles without ext_ack before abort (range 2..255).
REQ-002 SHALL have parameter IO_OUT_ADDR, default 12'hFFF, meaning the address of the output port register (write-only).
REQ-003 SHALL have parameter IO_IN_ADDR, default 12'hFFE, meaning the address of the input port (read-only).
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cpu_req  input  1  one-cycle access strobe from processor memory stage.
REQ-007 cpu_rw  input  1  1=write, 0=read.
REQ-008 cpu_addr  input  12  word address.
REQ-009 cpu_data  input  16  write data.
REQ-010 cpu_q  output  16  read data, registered, holds until the next completed read.
REQ-011 busy  output  1  high while state != IDLE; the controller freezes phase advance while busy=1.
REQ-012 ext_req  output  1  four-phase request to external memory.
REQ-013 ext_we  output  1  write qualifier, valid while ext_req=1.
REQ-014 ext_addr  output  12  latched address, and ext_wdata  output  16  latched write data.
REQ-015 ext_ack  input  1  four-phase acknowledge, and ext_rdata  input  16  read data, valid when ext_ack=1.
REQ-016 io_in  input  16  external input port, and io_out  output  16  output port register.
REQ-017 err_timeout  output  1  sticky timeout flag, and err_overrun  output  1  sticky flag for a request made while busy.
REQ-018 err_clr  input  1  synchronous clear of both sticky flags.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT, RELEASE.
- IDLE with cpu_req=1, cpu_addr not equal to either IO address -> latch addr/data/rw into ext_addr/ext_wdata/ext_we, clear timeout counter, go to WAIT.
REQ-020 IDLE with cpu_req=1, cpu_addr=IO_OUT_ADDR:
- write: io_out<=cpu_data on that edge.
- read: cpu_q<=16'h0000.
- State stays IDLE; busy stays 0; no ext_req.
REQ-021 IDLE with cpu_req=1, cpu_addr=IO_IN_ADDR:
- read: cpu_q<=io_in on that edge.
- write: ignored.
- State stays IDLE.
REQ-022 WAIT: ext_req=1 with ext_addr/ext_we/ext_wdata stable. The 8-bit counter increments each WAIT cycle.
REQ-023 WAIT with ext_ack=1 -> go to RELEASE; a read SHALL load cpu_q<=ext_rdata on that edge.
REQ-024 WAIT with ext_ack=0 and counter=TIMEOUT-1 -> set err_timeout, go to RELEASE; a read SHALL load cpu_q<=16'hFFFF.
REQ-025 If ext_ack=1 and the timeout condition occur in the same cycle, ack SHALL win: normal completion, err_timeout unchanged.
REQ-026 RELEASE: ext_req=0. Go to IDLE on the first cycle with ext_ack=0; stay in RELEASE while ext_ack=1, with no timeout in RELEASE.
REQ-027 Access latency with ack sampled in the first WAIT cycle:
- cpu_q valid 2 cycles after the cpu_req edge.
- busy high for exactly 2 cycles, provided ext_ack falls within one cycle.
REQ-028 cpu_req=1 while busy=1 SHALL be ignored (no latch, no state change) and SHALL set err_overrun.
REQ-029 err_clr=1 SHALL clear both flags. A set event in the same cycle as err_clr SHALL win (flag ends at 1).
REQ-030 ext_addr, ext_wdata and ext_we SHALL change only on acceptance in IDLE.

Reset
REQ-031 reset=0 SHALL immediately, regardless of the clock, force:
- state=IDLE, counter=0;
- ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0;
- cpu_q=0, io_out=0, err_timeout=0, err_overrun=0.
busy=0 follows from state=IDLE.
REQ-032 Reset asserted mid-WAIT SHALL abort the access: ext_req drops asynchronously and no cpu_q update occurs. After release, any ext_ack still high from that access SHALL be ignored while in IDLE.

Verification
REQ-033 Read 12'h010: ext_rdata=16'h1234, ack in first WAIT cycle and low the next cycle -> ext_req high 1 cycle, cpu_q=16'h1234 at cycle 2, busy high 2 cycles.
REQ-034 Write 12'h020 with data 16'hBEEF: ack delayed 5 cycles -> ext_we=1, ext_addr=12'h020, ext_wdata=16'hBEEF stable for all 6 WAIT cycles; cpu_q unchanged.
REQ-035 Read with no ack, TIMEOUT=64 -> err_timeout=1 after 64 WAIT cycles, cpu_q=16'hFFFF, return to IDLE; err_clr pulse -> err_timeout=0.
REQ-036 Write 16'h00A5 to 12'hFFF, then read 12'hFFE with io_in=16'h5A5A -> io_out=16'h00A5 next edge, cpu_q=16'h5A5A next edge, busy never 1.
REQ-037 cpu_req during WAIT -> err_overrun=1 and latched ext_addr unchanged. Ack and timeout coincident at counter=63 -> err_timeout stays 0.
REQ-038 reset=0 pulse mid-WAIT -> ext_req=0 and busy=0 without a clock edge, all outputs at reset values.
